collision_event_queue: RTL
==========================

COLLISION_EVENT_QUEUE -- requirements
Module: collision_event_queue

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 2, number of ball draw-request inputs (1..4).
REQ-002 SHALL have parameter NUM_OBJS, default 12, number of obstacle draw-request inputs (1..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event queue entries (power of 2, >=2).
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 4, per-pair suppression frames (1..15); used only with COLLISION_COOLDOWN_EN.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port startOfFrame  in  1  one-cycle pulse per frame.
REQ-008 SHALL have port ballDR  in  NUM_BALLS  per-ball draw request for the current pixel.
REQ-009 SHALL have port objDR  in  NUM_OBJS  per-obstacle draw request for the current pixel.
REQ-010 SHALL have port hit_pulse  out  NUM_BALLS*NUM_OBJS  one-cycle pulse per pair, index b*NUM_OBJS+o.
REQ-011 SHALL have port any_collision  out  1  combinational OR of all raw pair hits.
REQ-012 SHALL have port evt_valid  out  1  queue head valid.
REQ-013 SHALL have port evt_ready  in  1  consumer accepts the head.
REQ-014 SHALL have port evt_ball  out  clog2(NUM_BALLS) (min 1)  head ball index.
REQ-015 SHALL have port evt_obj  out  clog2(NUM_OBJS) (min 1)  head obstacle index.
REQ-016 SHALL have port overflow  out  1  sticky: event lost.
REQ-017 SHALL have port ovf_clr  in  1  synchronous clear of overflow.

Function
REQ-018 Raw hit[b][o] SHALL be ballDR[b] & objDR[o].
REQ-019 Per pair, a flag SHALL gate reporting: hit with flag clear -> hit_pulse high for exactly the next cycle and flag set.
REQ-020 startOfFrame SHALL clear all flags; on a simultaneous hit, the pre-edge flag value decides: clear -> pulse and flag set; set -> no pulse and flag cleared.
REQ-021 At the edge that raises hit_pulse, the pair's pending bit SHALL be set.
REQ-022 Each cycle, the lowest-index pending pair (ball-major) SHALL be pushed if the FIFO is not full, and its pending bit cleared at that edge.
REQ-023 Latency: raw hit in cycle N -> hit_pulse in N+1 -> evt_valid in N+2 (FWFT, empty queue).
REQ-024 Pop SHALL occur when evt_valid & evt_ready; push and pop in the same cycle SHALL be legal, count unchanged.
REQ-025 Full FIFO: pending bits SHALL be held, not dropped, and SHALL persist across startOfFrame.
REQ-026 A new pulse on a pair whose pending bit is still set SHALL set overflow and coalesce (one event).
REQ-027 overflow SHALL clear only on ovf_clr or reset; a same-cycle set takes priority over ovf_clr.
REQ-028 evt_ball/evt_obj SHALL hold while evt_valid & !evt_ready.

Reset
REQ-029 resetN low SHALL asynchronously zero all flags, pending bits, cooldown counters, FIFO pointers and count, hit_pulse, evt_valid and overflow.
REQ-030 Reset mid-operation SHALL discard queued and pending events; after release, the first output activity is a fresh pulse.

Configuration
REQ-031 Macro COLLISION_COOLDOWN_EN defined: each pair SHALL hold a counter loaded with COOLDOWN_FRAMES on pulse and decremented on each startOfFrame; reporting is allowed only at zero (replaces the REQ-020 frame clear).
REQ-032 Macro COLLISION_COOLDOWN_EN undefined: no counters exist; REQ-020 applies.

Structure
REQ-033 Package collision_pkg SHALL hold parameter defaults, index-width functions and the evt_t struct {ball index, obstacle index}.
REQ-034 The FIFO SHALL be a sub-module event_fifo (synchronous, FWFT, parametric width/depth, full/empty/count).

Verification
REQ-035 Ball0 & obj3 high for 40 cycles in one frame -> one hit_pulse[3] cycle; one event (0,3); evt_valid 2 cycles after first overlap.
REQ-036 Same cycle: ball0&obj1 and ball1&obj0 (NUM_OBJS=12) -> pulses [1] and [12]; events pop in order (0,1) then (1,0).
REQ-037 evt_ready=0, 9 distinct pairs hit, FIFO_DEPTH=8 -> count 8, 9th held pending, overflow=0; one pop -> 9th enqueued the next cycle.
REQ-038 Pair pending with FIFO full re-hits in next frame -> overflow=1, single queued event; ovf_clr -> 0.
REQ-039 COLLISION_COOLDOWN_EN with COOLDOWN_FRAMES=2, continuous overlap -> pulses in frames 0, 3, 6; without the macro -> one pulse every frame.
REQ-040 resetN low for 1 cycle with 3 events queued -> evt_valid=0, hit_pulse=0, overflow=0; next overlap -> normal pulse.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared defaults, index-width helper and the queued event record used by collision_event_queue.
package collision_pkg;

    localparam int DEF_NUM_BALLS       = 2;
    localparam int DEF_NUM_OBJS        = 12;
    localparam int DEF_FIFO_DEPTH      = 8;
    localparam int DEF_COOLDOWN_FRAMES = 4;

    localparam int MAX_BALLS = 4;
    localparam int MAX_OBJS  = 32;
    localparam int CD_W      = 4;

    // Index width with a floor of one bit, so single-entry ranges still get a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int EVT_BALL_W = idx_w(MAX_BALLS);
    localparam int EVT_OBJ_W  = idx_w(MAX_OBJS);

    typedef struct packed {
        logic [EVT_BALL_W-1:0] ball;
        logic [EVT_OBJ_W-1:0]  obj;
    } evt_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata_o shows the head whenever empty_o is low.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/collision_event_queue.sv
// Ball/obstacle overlap detector: one pulse per pair per frame, events queued in ball-major order.
// Optional per-pair frame cooldown when COLLISION_COOLDOWN_EN is defined.
module collision_event_queue
    import collision_pkg::*;
#(
    parameter int NUM_BALLS       = DEF_NUM_BALLS,
    parameter int NUM_OBJS        = DEF_NUM_OBJS,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [NUM_BALLS-1:0]          ballDR,
    input  logic [NUM_OBJS-1:0]           objDR,
    output logic [NUM_BALLS*NUM_OBJS-1:0] hit_pulse,
    output logic                          any_collision,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [idx_w(NUM_BALLS)-1:0]   evt_ball,
    output logic [idx_w(NUM_OBJS)-1:0]    evt_obj,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int NP    = NUM_BALLS * NUM_OBJS;
    localparam int BW    = idx_w(NUM_BALLS);
    localparam int OW    = idx_w(NUM_OBJS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (NUM_BALLS < 1 || NUM_BALLS > MAX_BALLS || NUM_OBJS < 1 || NUM_OBJS > MAX_OBJS ||
        COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 15 || FIFO_DEPTH < 2) begin : g_param_check
        $error("collision_event_queue: parameter out of range");
    end

    logic [NP-1:0]    raw_hit, report, frame_clr;
    logic [NP-1:0]    flag_q, flag_d, pend_q, pend_d, pulse_q;
    logic [NP-1:0]    push_sel, push_clr;
    logic             pend_any, push, pop, fifo_full, fifo_empty;
    logic             ovf_set, overflow_q, overflow_d;
    logic [CNT_W-1:0] fifo_count;
    evt_t             push_evt, head_evt;

    always_comb begin
        raw_hit = '0;
        for (int b = 0; b < NUM_BALLS; b++) begin
            for (int o = 0; o < NUM_OBJS; o++) begin
                raw_hit[b*NUM_OBJS+o] = ballDR[b] & objDR[o];
            end
        end
    end

    assign any_collision = |raw_hit;
    assign report        = raw_hit & ~flag_q;
    // On a clearing edge the flag re-arms only for a pair that reports in that same cycle.
    assign flag_d        = (frame_clr & report) | (~frame_clr & (flag_q | raw_hit));

`ifdef COLLISION_COOLDOWN_EN
    logic [NP-1:0][CD_W-1:0] cd_q, cd_d;

    always_comb begin
        frame_clr = '0;
        cd_d      = cd_q;
        for (int i = 0; i < NP; i++) begin
            frame_clr[i] = startOfFrame && (cd_q[i] == '0);
            if (report[i]) begin
                cd_d[i] = CD_W'(COOLDOWN_FRAMES);
            end else if (startOfFrame && cd_q[i] != '0) begin
                cd_d[i] = cd_q[i] - CD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cd_q <= '0;
        else         cd_q <= cd_d;
    end
`else
    assign frame_clr = {NP{startOfFrame}};
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        push_sel = '0;
        push_evt = '0;
        pend_any = 1'b0;
        for (int b = 0; b < NUM_BALLS; b++) begin
            for (int o = 0; o < NUM_OBJS; o++) begin
                if (!pend_any && pend_q[b*NUM_OBJS+o]) begin
                    pend_any               = 1'b1;
                    push_sel[b*NUM_OBJS+o] = 1'b1;
                    push_evt.ball          = EVT_BALL_W'(b);
                    push_evt.obj           = EVT_OBJ_W'(o);
                end
            end
        end
    end

    assign push       = pend_any && !fifo_full;
    assign push_clr   = push ? push_sel : '0;
    assign pend_d     = (pend_q & ~push_clr) | report;
    assign ovf_set    = |(report & pend_q & ~push_clr);
    assign overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    assign pop        = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flag_q     <= '0;
            pend_q     <= '0;
            pulse_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            flag_q     <= flag_d;
            pend_q     <= pend_d;
            pulse_q    <= report;
            overflow_q <= overflow_d;
        end
    end

    event_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .push_i  (push),
        .wdata_i (push_evt),
        .pop_i   (pop),
        .rdata_o (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign hit_pulse = pulse_q;
    assign overflow  = overflow_q;
    assign evt_valid = !fifo_empty;
    assign evt_ball  = BW'(head_evt.ball);
    assign evt_obj   = OW'(head_evt.obj);

endmodule
